// File: rtl/sys_if_arb_pkg.sv
// Shared types and constants for the sys_if bus arbiter.
// Used by sys_if_rr_picker and sys_if_arbiter.
package sys_if_arb_pkg;

    localparam int SYS_IF_AW = 32;
    localparam int SYS_IF_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_if_rr_picker.sv
// Combinational round-robin picker: returns the first set bit of req,
// searching upward from last_grant+1 and wrapping modulo N.
// Generic enough to be reused by other bus arbiters.
module sys_if_rr_picker
    import sys_if_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] grant,
    output logic          any_req
);

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        int idx;
        idx     = 0;
        grant   = last_grant;
        any_req = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % N;
            if (req[idx]) begin
                grant   = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sys_if_arbiter.sv
// Round-robin arbiter sharing the sys_if register bus among NUM_REQ masters.
// Serialises whole transactions and returns captured read data per requester.
// Optional feature: define SYS_IF_ARB_LOCK_EN to let a master keep the bus
// across transactions (atomic read-modify-write) via req_lock.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a request; picks the next master round-robin
//   ACCESS | address/data on the bus, write strobe in first cycle only,
//          | RD_WAIT extra cycles, then rdata captured
//   DONE   | req_done pulse to the granted master, pointer advanced
module sys_if_arbiter
    import sys_if_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RD_WAIT = 0
) (
    input  logic                           sys_if_clk,
    input  logic                           sys_if_rstn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_wen,
    input  logic [SYS_IF_AW*NUM_REQ-1:0]   req_addr,
    input  logic [SYS_IF_DW*NUM_REQ-1:0]   req_wdata,
    input  logic [NUM_REQ-1:0]             req_lock,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [SYS_IF_DW-1:0]           rsp_rdata,
    output logic                           sys_if_wen,
    output logic [SYS_IF_AW-1:0]           sys_if_addr,
    output logic [SYS_IF_DW-1:0]           sys_if_wdata,
    input  logic [SYS_IF_DW-1:0]           sys_if_rdata
);

    localparam int            IW       = idx_width(NUM_REQ);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
    localparam logic [3:0]    WAIT_TC  = 4'(RD_WAIT);

    arb_state_t          state;
    logic [IW-1:0]       last_grant;
    logic [IW-1:0]       grant_q;
    logic [IW-1:0]       pick;
    logic                pick_valid;
    logic [NUM_REQ-1:0]  eligible;
    logic [3:0]          wait_cnt;

`ifdef SYS_IF_ARB_LOCK_EN
    logic                lock_flag;
    logic [IW-1:0]       lock_owner;

    // While the bus is locked only the owner may be granted.
    always_comb begin
        eligible = req_valid;
        if (lock_flag) begin
            eligible = req_valid & (NUM_REQ'(1) << lock_owner);
        end
    end
`else
    logic                lock_unused;

    assign lock_unused = ^req_lock;

    // Pure round-robin: every pending request competes.
    always_comb begin
        eligible = req_valid;
    end
`endif

    sys_if_rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req        (eligible),
        .last_grant (last_grant),
        .grant      (pick),
        .any_req    (pick_valid)
    );

    // Transaction sequencer; every bus and response output is registered here.
    always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            state        <= IDLE;
            last_grant   <= LAST_RST;
            grant_q      <= '0;
            wait_cnt     <= '0;
            req_done     <= '0;
            rsp_rdata    <= '0;
            sys_if_wen   <= 1'b0;
            sys_if_addr  <= '0;
            sys_if_wdata <= '0;
`ifdef SYS_IF_ARB_LOCK_EN
            lock_flag    <= 1'b0;
            lock_owner   <= '0;
`endif
        end else begin
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q      <= pick;
                        sys_if_addr  <= req_addr[SYS_IF_AW*pick +: SYS_IF_AW];
                        sys_if_wdata <= req_wdata[SYS_IF_DW*pick +: SYS_IF_DW];
                        sys_if_wen   <= req_wen[pick];
                        wait_cnt     <= '0;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Strobe only in the first ACCESS cycle so a write lands once.
                    sys_if_wen <= 1'b0;
                    if (wait_cnt == WAIT_TC) begin
                        rsp_rdata         <= sys_if_rdata;
                        req_done[grant_q] <= 1'b1;
                        state             <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                DONE: begin
                    last_grant <= grant_q;
                    wait_cnt   <= '0;
                    state      <= IDLE;
`ifdef SYS_IF_ARB_LOCK_EN
                    lock_flag  <= req_lock[grant_q];
                    lock_owner <= grant_q;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_if_arbiter.sv
// Directed bench for sys_if_arbiter: instance A (RD_WAIT=0) with a scratch
// register decoder, instance B (RD_WAIT=3) with a constant-register decoder.
module tb_sys_if_arbiter;

    localparam int          NREQ        = 4;
    localparam logic [31:0] NUM_CHANNEL = 32'd8;
    localparam logic [31:0] SCRATCH_RST = 32'hA5A5_5A5A;

    logic clk;
    logic rstn;
    int   cyc;
    int   checks;
    int   errors;

    // instance A
    logic [NREQ-1:0]    a_req_valid, a_req_wen, a_req_lock, a_req_done;
    logic [32*NREQ-1:0] a_req_addr, a_req_wdata;
    logic [31:0]        a_rsp_rdata, a_addr, a_wdata, a_rdata;
    logic               a_wen;
    logic [31:0]        scratch;

    // instance B
    logic [NREQ-1:0]    b_req_valid, b_req_wen, b_req_lock, b_req_done;
    logic [32*NREQ-1:0] b_req_addr, b_req_wdata;
    logic [31:0]        b_rsp_rdata, b_addr, b_wdata, b_rdata;
    logic               b_wen;

    sys_if_arbiter #(.NUM_REQ(NREQ), .RD_WAIT(0)) u_dut_a (
        .sys_if_clk   (clk),
        .sys_if_rstn  (rstn),
        .req_valid    (a_req_valid),
        .req_wen      (a_req_wen),
        .req_addr     (a_req_addr),
        .req_wdata    (a_req_wdata),
        .req_lock     (a_req_lock),
        .req_done     (a_req_done),
        .rsp_rdata    (a_rsp_rdata),
        .sys_if_wen   (a_wen),
        .sys_if_addr  (a_addr),
        .sys_if_wdata (a_wdata),
        .sys_if_rdata (a_rdata)
    );

    sys_if_arbiter #(.NUM_REQ(NREQ), .RD_WAIT(3)) u_dut_b (
        .sys_if_clk   (clk),
        .sys_if_rstn  (rstn),
        .req_valid    (b_req_valid),
        .req_wen      (b_req_wen),
        .req_addr     (b_req_addr),
        .req_wdata    (b_req_wdata),
        .req_lock     (b_req_lock),
        .req_done     (b_req_done),
        .rsp_rdata    (b_rsp_rdata),
        .sys_if_wen   (b_wen),
        .sys_if_addr  (b_addr),
        .sys_if_wdata (b_wdata),
        .sys_if_rdata (b_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register decoder model for A: scratch at 0x10, constant at 0x14.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) scratch <= SCRATCH_RST;
        else if (a_wen && a_addr == 32'h10) scratch <= a_wdata;
    end

    assign a_rdata = (a_addr == 32'h10) ? scratch :
                     (a_addr == 32'h14) ? NUM_CHANNEL : 32'h0;
    assign b_rdata = (b_addr == 32'h14) ? NUM_CHANNEL : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One transaction on A by requester idx; returns latency, done vector, rdata, strobe count.
    task automatic a_txn(input int idx, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic [3:0] dv,
                         output logic [31:0] rd, output int wcnt);
        a_req_wen[idx]            = wen;
        a_req_addr[32*idx +: 32]  = addr;
        a_req_wdata[32*idx +: 32] = wdata;
        a_req_valid[idx]          = 1'b1;
        lat  = -1;
        dv   = '0;
        rd   = '0;
        wcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (a_wen) wcnt++;
            if (a_req_done != '0) begin
                lat = c;
                dv  = a_req_done;
                rd  = a_rsp_rdata;
                break;
            end
        end
        a_req_valid[idx] = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          idx;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          lat, wcnt, prev, n, ord_n, n1;
        int          ord[3];
        int          exp_ord[3];
        logic [3:0]  dv;
        logic [31:0] rd;
        bit          pend0, pend1;

        cyc = 0; checks = 0; errors = 0;
        rstn = 1'b1;
        a_req_valid = '0; a_req_wen = '0; a_req_lock = '0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = '0; b_req_wen = '0; b_req_lock = '0; b_req_addr = '0; b_req_wdata = '0;

        vecs[0] = '{0, 1'b0, 32'h10, 32'h0,         32'hA5A5_5A5A};
        vecs[1] = '{2, 1'b1, 32'h10, 32'h1234_5678, 32'hA5A5_5A5A};
        vecs[2] = '{1, 1'b0, 32'h10, 32'h0,         32'h1234_5678};
        vecs[3] = '{3, 1'b0, 32'h20, 32'h0,         32'h0};
        vecs[4] = '{3, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[5] = '{0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
        vecs[6] = '{1, 1'b0, 32'h14, 32'h0,         NUM_CHANNEL};

        #2 rstn = 1'b0;
        #1;
        chk("rst_done",  32'(a_req_done), 32'h0);
        chk("rst_rdata", a_rsp_rdata, 32'h0);
        chk("rst_wen",   32'(a_wen), 32'h0);
        chk("rst_addr",  a_addr, 32'h0);
        chk("rst_wdata", a_wdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Table-driven single transactions on A.
        foreach (vecs[i]) begin
            a_txn(vecs[i].idx, vecs[i].wen, vecs[i].addr, vecs[i].wdata, lat, dv, rd, wcnt);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_done", i), 32'(dv), 32'(1) << vecs[i].idx);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_wstrobes", i), 32'(wcnt), vecs[i].wen ? 32'd1 : 32'd0);
        end

        // Instance B: RD_WAIT=3 read of 0x14 from two different requesters.
        for (int r = 0; r < 4; r += 3) begin
            b_req_addr[32*r +: 32] = 32'h14;
            b_req_valid[r] = 1'b1;
            lat = -1; dv = '0; rd = '0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (b_req_done != '0) begin lat = c; dv = b_req_done; rd = b_rsp_rdata; break; end
            end
            b_req_valid[r] = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("b%0d_latency", r), 32'(lat), 32'd5);
            chk($sformatf("b%0d_done", r), 32'(dv), 32'(1) << r);
            chk($sformatf("b%0d_rdata", r), rd, NUM_CHANNEL);
        end

        // All four valid continuously from reset: order 0,1,2,3,... every 3 cycles.
        @(posedge clk); #1;
        rstn = 1'b0;
        a_req_valid = 4'hF;
        a_req_wen = '0;
        @(negedge clk);
        rstn = 1'b1;
        n = 0; prev = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            @(posedge clk); #1;
            if (a_req_done != '0) begin
                chk($sformatf("rr_grant%0d", n), 32'(a_req_done), 32'(1) << (n % 4));
                if (n > 0) chk($sformatf("rr_gap%0d", n), 32'(cyc - prev), 32'd3);
                prev = cyc;
                n++;
            end
        end
        chk("rr_count", 32'(n), 32'd8);
        a_req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset during ACCESS of a write from req 2.
        a_req_wen[2] = 1'b1;
        a_req_addr[64 +: 32] = 32'h10;
        a_req_wdata[64 +: 32] = 32'h0000_0055;
        a_req_valid[2] = 1'b1;
        @(posedge clk); #1;
        chk("mid_wen_before_rst", 32'(a_wen), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_done",  32'(a_req_done), 32'h0);
        chk("mid_rst_rdata", a_rsp_rdata, 32'h0);
        chk("mid_rst_wen",   32'(a_wen), 32'h0);
        chk("mid_rst_addr",  a_addr, 32'h0);
        chk("mid_rst_wdata", a_wdata, 32'h0);
        a_req_valid = 4'hF;
        a_req_wen = '0;
        @(posedge clk); #1;
        chk("mid_rst_hold_done", 32'(a_req_done), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        dv = '0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (a_req_done != '0) begin dv = a_req_done; break; end
        end
        chk("post_rst_first_grant", 32'(dv), 32'h1);
        a_req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Lock scenario: last_grant=0, then req 1 locked read + write with req 0 waiting.
        do_reset();
        @(posedge clk); #1;
        a_txn(0, 1'b0, 32'h10, 32'h0, lat, dv, rd, wcnt);
        a_req_addr[0 +: 32] = 32'h20;
        a_req_wen[0] = 1'b0;
        a_req_valid[0] = 1'b1;
        a_req_addr[32 +: 32] = 32'h10;
        a_req_wen[1] = 1'b0;
        a_req_lock[1] = 1'b1;
        a_req_valid[1] = 1'b1;
        ord_n = 0; n1 = 0; pend0 = 1'b0; pend1 = 1'b0;
        ord = '{-1, -1, -1};
        for (int c = 0; c < 40 && ord_n < 3; c++) begin
            @(posedge clk); #1;
            if (pend1) begin
                if (n1 == 1) begin
                    a_req_wen[1] = 1'b1;
                    a_req_wdata[32 +: 32] = 32'hCAFE_0001;
                    a_req_lock[1] = 1'b0;
                end else begin
                    a_req_valid[1] = 1'b0;
                end
                pend1 = 1'b0;
            end
            if (pend0) begin
                a_req_valid[0] = 1'b0;
                pend0 = 1'b0;
            end
            if (a_req_done != '0) begin
                for (int b = 0; b < NREQ; b++) if (a_req_done[b]) ord[ord_n] = b;
                ord_n++;
                if (a_req_done[1]) begin n1++; pend1 = 1'b1; end
                if (a_req_done[0]) pend0 = 1'b1;
            end
        end
        a_req_valid = '0;
        a_req_lock = '0;
`ifdef SYS_IF_ARB_LOCK_EN
        exp_ord = '{1, 1, 0};
`else
        exp_ord = '{1, 0, 1};
`endif
        for (int k = 0; k < 3; k++)
            chk($sformatf("lock_order%0d", k), 32'(ord[k]), 32'(exp_ord[k]));
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
